// File: rtl/ecall_io_unit.sv
// ecall_io_unit: per-channel input FIFOs serving core ecall reads/writes with a stall handshake
module ecall_io_unit #(
  parameter int DATA_W     = 32,
  parameter int NCH        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ecall_req,
  input  logic                  ecall_dir,
  input  logic [SEL_W-1:0]      ecall_sel,
  input  logic [DATA_W-1:0]     ecall_wdata,
  output logic                  stall,
  output logic                  rdata_valid,
  output logic [DATA_W-1:0]     rdata,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [NCH-1:0]        in_finish,
  output logic [DATA_W-1:0]     out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic [NCH-1:0]        overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NS = 2 ** SEL_W;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t                  r_state, w_next;
  logic [NCH-1:0]          r_fin_prev, r_ovf, w_push, w_pop, w_empty, w_full;
  logic [NCH*DATA_W-1:0]   w_heads_n;
  logic [NS*DATA_W-1:0]    w_heads;
  logic [NS-1:0]           w_empty_x;
  logic [DATA_W-1:0]       w_head, r_rdata, r_out_data;
  logic [SEL_W-1:0]        r_out_sel;
  logic                    w_sel_ok, w_pop_en, r_is_read;
  assign w_sel_ok  = 32'(ecall_sel) < NCH;
  assign w_push    = in_finish & ~r_fin_prev;
  assign w_empty_x = NS'(w_empty);
  assign w_heads   = (NS*DATA_W)'(w_heads_n);
  assign w_head    = w_heads[ecall_sel*DATA_W +: DATA_W];
  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
      logic [PW:0]       r_wp, r_rp;
      assign w_empty[c] = r_wp == r_rp;
      assign w_full[c]  = r_wp == {~r_rp[PW], r_rp[PW-1:0]};
      assign w_pop[c]   = w_pop_en && 32'(ecall_sel) == c;
      assign w_heads_n[c*DATA_W +: DATA_W] = r_mem[r_rp[PW-1:0]];
      always_ff @(posedge clk) begin
        if (reset) begin
          r_wp <= '0;
          r_rp <= '0;
        end else begin
          // a pop frees the head slot in the same cycle, so a full FIFO still accepts
          if (w_push[c] && (!w_full[c] || w_pop[c])) begin
            r_mem[r_wp[PW-1:0]] <= in_data[c*DATA_W +: DATA_W];
            r_wp <= r_wp + 1'b1;
          end
          if (w_pop[c]) r_rp <= r_rp + 1'b1;
        end
      end
    end
  endgenerate
  always_comb begin
    w_next   = r_state;
    w_pop_en = 1'b0;
    case (r_state)
      IDLE: if (ecall_req) begin
        if (ecall_dir || !w_sel_ok) w_next = DONE;
        else if (!w_empty_x[ecall_sel]) begin
          w_pop_en = 1'b1;
          w_next   = DONE;
        end else w_next = WAIT;
      end
      WAIT: if (!ecall_req) w_next = IDLE;
        else if (w_sel_ok && !w_empty_x[ecall_sel]) begin
          w_pop_en = 1'b1;
          w_next   = DONE;
        end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rdata    <= '0;
      r_out_data <= '0;
      r_out_sel  <= '0;
      r_is_read  <= 1'b0;
      r_fin_prev <= '1;
      r_ovf      <= '0;
    end else begin
      r_state    <= w_next;
      r_fin_prev <= in_finish;
      r_ovf      <= r_ovf | (w_push & w_full & ~w_pop);
      if (w_pop_en) r_rdata <= w_head;
      else if (r_state == IDLE && ecall_req && !ecall_dir && !w_sel_ok) r_rdata <= '0;
      if (r_state == IDLE && ecall_req && ecall_dir && w_sel_ok) begin
        r_out_data <= ecall_wdata;
        r_out_sel  <= ecall_sel;
      end
      if (r_state == IDLE) r_is_read <= !ecall_dir;
    end
  end
  assign stall       = ecall_req && r_state != DONE;
  assign rdata_valid = r_state == DONE && r_is_read;
  assign rdata       = r_rdata;
  assign out_data    = r_out_data;
  assign out_sel     = r_out_sel;
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_ecall_io_unit.sv
// tb_ecall_io_unit: table-driven cycle vectors plus hand-written multi-cycle sequences
module tb_ecall_io_unit;
  logic        clk = 0, reset = 1, ecall_req = 0, ecall_dir = 0;
  logic [1:0]  ecall_sel = 0, in_finish = 0;
  logic [31:0] ecall_wdata = 0;
  logic [63:0] in_data = 0;
  logic        stall, rdata_valid;
  logic [31:0] rdata, out_data;
  logic [1:0]  out_sel, overflow;
  int n_tests = 0, n_fail = 0;

  ecall_io_unit #(.DATA_W(32), .NCH(2), .FIFO_DEPTH(4), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .ecall_req(ecall_req), .ecall_dir(ecall_dir),
    .ecall_sel(ecall_sel), .ecall_wdata(ecall_wdata), .stall(stall),
    .rdata_valid(rdata_valid), .rdata(rdata), .in_data(in_data),
    .in_finish(in_finish), .out_data(out_data), .out_sel(out_sel), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fin;
    logic [31:0] d0, d1;
    logic        req, dir;
    logic [1:0]  sel;
    logic [31:0] wd;
    logic        st, rv;
    logic [31:0] rd, od;
    logic [1:0]  os, ov;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic [1:0] fin, logic [31:0] d0, logic [31:0] d1, logic req, logic dir,
                     logic [1:0] sel, logic [31:0] wd, logic st, logic rv, logic [31:0] rd,
                     logic [31:0] od, logic [1:0] os, logic [1:0] ov);
    vec_t v;
    v.fin = fin; v.d0 = d0; v.d1 = d1; v.req = req; v.dir = dir; v.sel = sel; v.wd = wd;
    v.st = st; v.rv = rv; v.rd = rd; v.od = od; v.os = os; v.ov = ov;
    tbl.push_back(v);
  endtask

  task automatic push(int ch, logic [31:0] val);
    if (ch == 0) in_data[31:0] = val; else in_data[63:32] = val;
    in_finish[ch] = 1'b1;
    tick();
    in_finish[ch] = 1'b0;
    tick();
  endtask

  task automatic rd_op(logic [1:0] sel, logic [31:0] exp, string nm);
    ecall_req = 1; ecall_dir = 0; ecall_sel = sel;
    #1 chk({nm, " stall"}, 32'(stall), 1);
    tick();
    #1 chk({nm, " rel"}, 32'(stall), 0);
    chk({nm, " valid"}, 32'(rdata_valid), 1);
    chk({nm, " rdata"}, rdata, exp);
    ecall_req = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // basic read on channel 1
    add(0, 0, 0,    0, 0, 0, 0,            0, 0, 0,    0, 0, 0);
    add(2, 0, 'hAB, 0, 0, 0, 0,            0, 0, 0,    0, 0, 0);
    add(0, 0, 'hAB, 1, 0, 1, 0,            1, 0, 0,    0, 0, 0);
    add(0, 0, 'hAB, 1, 0, 1, 0,            0, 1, 'hAB, 0, 0, 0);
    add(0, 0, 'hAB, 0, 0, 0, 0,            0, 0, 'hAB, 0, 0, 0);
    // write, out-of-range write, out-of-range read
    add(0, 0, 0, 1, 1, 1, 32'hDEADBEEF,    1, 0, 'hAB, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 32'hDEADBEEF,    0, 0, 'hAB, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,               0, 0, 'hAB, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 1, 1, 3, 32'h12345678,    1, 0, 'hAB, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 1, 1, 3, 32'h12345678,    0, 0, 'hAB, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,               0, 0, 'hAB, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 1, 0, 3, 0,               1, 0, 'hAB, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 1, 0, 3, 0,               0, 1, 0,    32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,               0, 0, 0,    32'hDEADBEEF, 1, 0);
    // five pushes into a depth-4 FIFO: the fifth is dropped
    for (int k = 1; k <= 5; k++) begin
      add(1, k, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0);
      add(0, k, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, (k == 5) ? 2'd1 : 2'd0);
    end
    for (int k = 1; k <= 4; k++) begin
      add(0, 0, 0, 1, 0, 0, 0, 1, 0, (k == 1) ? 0 : k - 1, 32'hDEADBEEF, 1, 1);
      add(0, 0, 0, 1, 0, 0, 0, 0, 1, k,                    32'hDEADBEEF, 1, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, k,                    32'hDEADBEEF, 1, 1);
    end
    // fifth read blocks, then is aborted
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 4, 32'hDEADBEEF, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 4, 32'hDEADBEEF, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'hDEADBEEF, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'hDEADBEEF, 1, 1);

    tick(); tick();
    chk("reset stall", 32'(stall), 0);
    chk("reset valid", 32'(rdata_valid), 0);
    chk("reset rdata", rdata, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_sel", 32'(out_sel), 0);
    chk("reset overflow", 32'(overflow), 0);
    reset = 0;

    foreach (tbl[i]) begin
      in_finish = tbl[i].fin; in_data = {tbl[i].d1, tbl[i].d0};
      ecall_req = tbl[i].req; ecall_dir = tbl[i].dir; ecall_sel = tbl[i].sel;
      ecall_wdata = tbl[i].wd;
      #1;
      chk($sformatf("r%0d stall", i), 32'(stall), 32'(tbl[i].st));
      chk($sformatf("r%0d valid", i), 32'(rdata_valid), 32'(tbl[i].rv));
      chk($sformatf("r%0d rdata", i), rdata, tbl[i].rd);
      chk($sformatf("r%0d out_data", i), out_data, tbl[i].od);
      chk($sformatf("r%0d out_sel", i), 32'(out_sel), 32'(tbl[i].os));
      chk($sformatf("r%0d overflow", i), 32'(overflow), 32'(tbl[i].ov));
      tick();
    end

    // blocking read: wait 10 cycles, then a push releases it
    ecall_req = 1; ecall_dir = 0; ecall_sel = 0;
    for (int k = 0; k < 10; k++) begin
      #1 chk($sformatf("block w%0d stall", k), 32'(stall), 1);
      tick();
    end
    in_data[31:0] = 32'h1234; in_finish = 2'b01;
    #1 chk("block push stall", 32'(stall), 1);
    tick();
    in_finish = 0;
    #1 chk("block pop stall", 32'(stall), 1);
    chk("block pop valid", 32'(rdata_valid), 0);
    tick();
    #1 chk("block done stall", 32'(stall), 0);
    chk("block done valid", 32'(rdata_valid), 1);
    chk("block done rdata", rdata, 32'h1234);
    ecall_req = 0;
    tick();

    // reset with finish held high: no push, overflow cleared
    in_data = {32'h77, 32'h66}; in_finish = 2'b11; reset = 1;
    tick(); tick();
    chk("rst2 overflow", 32'(overflow), 0);
    chk("rst2 out_data", out_data, 0);
    reset = 0;
    tick(); tick();
    in_finish = 0;
    tick();
    for (int ch = 0; ch < 2; ch++) begin
      ecall_req = 1; ecall_dir = 0; ecall_sel = 2'(ch);
      #1 chk($sformatf("held ch%0d stall", ch), 32'(stall), 1);
      tick();
      #1 chk($sformatf("held ch%0d wait", ch), 32'(stall), 1);
      ecall_req = 0;
      #1 chk($sformatf("held ch%0d abort", ch), 32'(stall), 0);
      tick();
      #1 chk($sformatf("held ch%0d idle valid", ch), 32'(rdata_valid), 0);
    end

    // full FIFO with a push and pop in the same cycle
    for (int k = 1; k <= 4; k++) push(0, k);
    in_data[31:0] = 9; in_finish = 2'b01;
    ecall_req = 1; ecall_dir = 0; ecall_sel = 0;
    #1 chk("fullpop stall", 32'(stall), 1);
    tick();
    in_finish = 0;
    #1 chk("fullpop valid", 32'(rdata_valid), 1);
    chk("fullpop rdata", rdata, 1);
    chk("fullpop overflow", 32'(overflow), 0);
    ecall_req = 0;
    tick();
    rd_op(0, 2, "fp2");
    rd_op(0, 3, "fp3");
    rd_op(0, 4, "fp4");
    rd_op(0, 9, "fp9");
    chk("fullpop overflow end", 32'(overflow), 0);

    // reset while blocked in WAIT drops FIFO contents
    push(1, 32'h55);
    ecall_req = 1; ecall_dir = 0; ecall_sel = 0;
    tick(); tick();
    #1 chk("rstwait stall", 32'(stall), 1);
    reset = 1;
    tick();
    reset = 0; ecall_req = 0;
    #1 chk("rstwait after stall", 32'(stall), 0);
    chk("rstwait after valid", 32'(rdata_valid), 0);
    tick();
    ecall_req = 1; ecall_sel = 1;
    #1 chk("rstwait ch1 stall", 32'(stall), 1);
    tick();
    #1 chk("rstwait ch1 empty", 32'(stall), 1);
    ecall_req = 0;
    tick();
    push(1, 32'h66);
    rd_op(1, 32'h66, "post-abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
